// File: rtl/axi_cmd_pkg.sv
// Shared types for the AXI command scheduler: command bundles,
// scheduler states, grant tracking and burst encodings.
package axi_cmd_pkg;

    localparam int AXI_W = 32;
    localparam int AXI_S = 3;
    localparam int AXI_L = AXI_W / 8;
    localparam int AXI_B = AXI_S - 1;

    localparam logic [AXI_B-1:0] BURST_FIXED = 2'd0;
    localparam logic [AXI_B-1:0] BURST_INCR  = 2'd1;
    localparam logic [AXI_B-1:0] BURST_WRAP  = 2'd2;

    typedef struct packed {
        logic [AXI_W-1:0] addr;
        logic [AXI_L-1:0] len;
        logic [AXI_L-1:0] strb;
        logic [AXI_S-1:0] size;
        logic [AXI_B-1:0] burst;
        logic [AXI_W-1:0] data;
        logic [AXI_L-1:0] id;
    } wr_cmd_t;

    typedef struct packed {
        logic [AXI_W-1:0] addr;
        logic [AXI_L-1:0] id;
        logic [AXI_L-1:0] len;
        logic [AXI_S-1:0] size;
        logic [AXI_B-1:0] burst;
    } rd_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE_WR = 3'd1,
        S_WAIT_WR  = 3'd2,
        S_ISSUE_RD = 3'd3,
        S_WAIT_RD  = 3'd4
    } sched_state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/axi_cmd_sched_if.sv
// Bus bundle between the host and the command scheduler: request push
// handshakes, command outputs to the AXI master, start/done, status.
// master: host side (drives requests and done pulses).
// slave : scheduler side (drives ready, commands, starts, busy, levels).
interface axi_cmd_sched_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3,
    parameter int DEPTH = 4
);
    localparam int LW  = WIDTH / 8;
    localparam int BW  = SIZE - 1;
    localparam int LVW = $clog2(DEPTH) + 1;

    logic             wr_req_valid;
    logic             wr_req_ready;
    logic [WIDTH-1:0] wr_req_addr;
    logic [LW-1:0]    wr_req_len;
    logic [LW-1:0]    wr_req_strb;
    logic [SIZE-1:0]  wr_req_size;
    logic [BW-1:0]    wr_req_burst;
    logic [WIDTH-1:0] wr_req_data;
    logic [LW-1:0]    wr_req_id;

    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [WIDTH-1:0] rd_req_addr;
    logic [LW-1:0]    rd_req_id;
    logic [LW-1:0]    rd_req_len;
    logic [SIZE-1:0]  rd_req_size;
    logic [BW-1:0]    rd_req_burst;

    logic [WIDTH-1:0] awaddr;
    logic [LW-1:0]    awlen;
    logic [LW-1:0]    wstrb;
    logic [SIZE-1:0]  awsize;
    logic [BW-1:0]    awburst;
    logic [WIDTH-1:0] wdata;
    logic [LW-1:0]    awid;

    logic [WIDTH-1:0] araddr;
    logic [LW-1:0]    arid;
    logic [LW-1:0]    arlen;
    logic [SIZE-1:0]  arsize;
    logic [BW-1:0]    arburst;

    logic             wr_start;
    logic             rd_start;
    logic             wr_done;
    logic             rd_done;
    logic             busy;
    logic [LVW-1:0]   wr_level;
    logic [LVW-1:0]   rd_level;

    modport master (
        output wr_req_valid, wr_req_addr, wr_req_len, wr_req_strb,
        output wr_req_size, wr_req_burst, wr_req_data, wr_req_id,
        output rd_req_valid, rd_req_addr, rd_req_id, rd_req_len,
        output rd_req_size, rd_req_burst,
        output wr_done, rd_done,
        input  wr_req_ready, rd_req_ready,
        input  awaddr, awlen, wstrb, awsize, awburst, wdata, awid,
        input  araddr, arid, arlen, arsize, arburst,
        input  wr_start, rd_start, busy, wr_level, rd_level
    );

    modport slave (
        input  wr_req_valid, wr_req_addr, wr_req_len, wr_req_strb,
        input  wr_req_size, wr_req_burst, wr_req_data, wr_req_id,
        input  rd_req_valid, rd_req_addr, rd_req_id, rd_req_len,
        input  rd_req_size, rd_req_burst,
        input  wr_done, rd_done,
        output wr_req_ready, rd_req_ready,
        output awaddr, awlen, wstrb, awsize, awburst, wdata, awid,
        output araddr, arid, arlen, arsize, arburst,
        output wr_start, rd_start, busy, wr_level, rd_level
    );

endinterface

// File: rtl/axi_cmd_fifo.sv
// Synchronous FIFO with show-ahead head output and occupancy count.
// Ports: push/pop strobes, din/dout (dout = head), full, empty, level.
module axi_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LVW  = AW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   din,
    output logic [W-1:0]   dout,
    output logic           full,
    output logic           empty,
    output logic [LVW-1:0] level
);

    localparam logic [LVW-1:0] FULL_CNT = LVW'(DEPTH);

    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [LVW-1:0] cnt;
    logic           do_push;
    logic           do_pop;

    // Pushes into a full FIFO and pops from an empty one are dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign level = cnt;
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            cnt <= cnt + LVW'(do_push) - LVW'(do_pop);
        end
    end

endmodule

// File: rtl/axi_cmd_sched.sv
// Command scheduler: queues write/read requests, round-robins between
// them and issues one command at a time to the AXI master.
// Ports: clk, resetn (sync, active-high), bus (slave side of the
// request/command bundle: pushes, aw/w/ar commands, start/done,
// busy and FIFO levels).
module axi_cmd_sched #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    axi_cmd_sched_if.slave bus
);
    import axi_cmd_pkg::*;

    localparam int LW = WIDTH / 8;
    localparam int BW = SIZE - 1;

    wr_cmd_t      wr_in;
    wr_cmd_t      wr_head;
    wr_cmd_t      wr_cmd_q;
    rd_cmd_t      rd_in;
    rd_cmd_t      rd_head;
    rd_cmd_t      rd_cmd_q;

    logic         wr_full;
    logic         wr_empty;
    logic         wr_pop;
    logic         rd_full;
    logic         rd_empty;
    logic         rd_pop;

    sched_state_e state_q;
    sched_state_e state_d;
    grant_e       grant_q;
    grant_e       grant_d;

    assign wr_in = '{
        addr:  AXI_W'(bus.wr_req_addr),
        len:   AXI_L'(bus.wr_req_len),
        strb:  AXI_L'(bus.wr_req_strb),
        size:  AXI_S'(bus.wr_req_size),
        burst: AXI_B'(bus.wr_req_burst),
        data:  AXI_W'(bus.wr_req_data),
        id:    AXI_L'(bus.wr_req_id)
    };

    assign rd_in = '{
        addr:  AXI_W'(bus.rd_req_addr),
        id:    AXI_L'(bus.rd_req_id),
        len:   AXI_L'(bus.rd_req_len),
        size:  AXI_S'(bus.rd_req_size),
        burst: AXI_B'(bus.rd_req_burst)
    };

    axi_cmd_fifo #(
        .W     ($bits(wr_cmd_t)),
        .DEPTH (DEPTH)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (resetn),
        .push  (bus.wr_req_valid),
        .pop   (wr_pop),
        .din   (wr_in),
        .dout  (wr_head),
        .full  (wr_full),
        .empty (wr_empty),
        .level (bus.wr_level)
    );

    axi_cmd_fifo #(
        .W     ($bits(rd_cmd_t)),
        .DEPTH (DEPTH)
    ) u_rd_fifo (
        .clk   (clk),
        .rst   (resetn),
        .push  (bus.rd_req_valid),
        .pop   (rd_pop),
        .din   (rd_in),
        .dout  (rd_head),
        .full  (rd_full),
        .empty (rd_empty),
        .level (bus.rd_level)
    );

    assign bus.wr_req_ready = !wr_full;
    assign bus.rd_req_ready = !rd_full;

    // State, grant history and the command holding registers. A channel's
    // command registers only change when that channel is popped.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= S_IDLE;
            grant_q  <= GRANT_RD;
            wr_cmd_q <= '0;
            rd_cmd_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (wr_pop) begin
                wr_cmd_q <= wr_head;
            end
            if (rd_pop) begin
                rd_cmd_q <= rd_head;
            end
        end
    end

    // Done pulses only matter in the matching WAIT state; ISSUE always
    // moves on, so a done coincident with start is dropped.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        wr_pop  = 1'b0;
        rd_pop  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!wr_empty && (rd_empty || grant_q == GRANT_RD)) begin
                    wr_pop  = 1'b1;
                    grant_d = GRANT_WR;
                    state_d = S_ISSUE_WR;
                end else if (!rd_empty) begin
                    rd_pop  = 1'b1;
                    grant_d = GRANT_RD;
                    state_d = S_ISSUE_RD;
                end
            end
            S_ISSUE_WR: state_d = S_WAIT_WR;
            S_WAIT_WR: begin
                if (bus.wr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE_RD: state_d = S_WAIT_RD;
            S_WAIT_RD: begin
                if (bus.rd_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.wr_start = (state_q == S_ISSUE_WR);
    assign bus.rd_start = (state_q == S_ISSUE_RD);
    assign bus.busy     = (state_q != S_IDLE);

    assign bus.awaddr  = WIDTH'(wr_cmd_q.addr);
    assign bus.awlen   = LW'(wr_cmd_q.len);
    assign bus.wstrb   = LW'(wr_cmd_q.strb);
    assign bus.awsize  = SIZE'(wr_cmd_q.size);
    assign bus.awburst = BW'(wr_cmd_q.burst);
    assign bus.wdata   = WIDTH'(wr_cmd_q.data);
    assign bus.awid    = LW'(wr_cmd_q.id);

    assign bus.araddr  = WIDTH'(rd_cmd_q.addr);
    assign bus.arid    = LW'(rd_cmd_q.id);
    assign bus.arlen   = LW'(rd_cmd_q.len);
    assign bus.arsize  = SIZE'(rd_cmd_q.size);
    assign bus.arburst = BW'(rd_cmd_q.burst);

endmodule

// File: tb/tb_axi_cmd_sched.sv
// Testbench for axi_cmd_sched: scoreboarded issue checks plus
// per-scenario tasks for latency, fill, arbitration, stray done, reset.
module tb_axi_cmd_sched;
    import axi_cmd_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    axi_cmd_sched_if #(.WIDTH(32), .SIZE(3), .DEPTH(4)) bus ();

    axi_cmd_sched #(.WIDTH(32), .SIZE(3), .DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    wr_cmd_t wr_q [$];
    rd_cmd_t rd_q [$];
    int      log_q [$];

    wr_cmd_t wg, we;
    rd_cmd_t rg, re;

    function automatic logic [125:0] all_cmd();
        all_cmd = {bus.awaddr, bus.awlen, bus.wstrb, bus.awsize,
                   bus.awburst, bus.wdata, bus.awid, bus.araddr,
                   bus.arid, bus.arlen, bus.arsize, bus.arburst};
    endfunction

    function automatic wr_cmd_t mk_wr(input logic [3:0] id);
        wr_cmd_t c;
        c.addr  = 32'h1000 + 32'(id) * 32'h100;
        c.len   = id;
        c.strb  = ~id;
        c.size  = 3'd2;
        c.burst = BURST_INCR;
        c.data  = {4{id, 4'hA}};
        c.id    = id;
        return c;
    endfunction

    function automatic rd_cmd_t mk_rd(input logic [3:0] id);
        rd_cmd_t c;
        c.addr  = 32'h8000 + 32'(id) * 32'h10;
        c.id    = id;
        c.len   = id + 4'd1;
        c.size  = 3'd3;
        c.burst = BURST_WRAP;
        return c;
    endfunction

    // Scoreboard: every start must match the oldest pushed command.
    always @(negedge clk) begin
        if (resetn === 1'b0 && bus.wr_start === 1'b1) begin
            wg.addr  = bus.awaddr;
            wg.len   = bus.awlen;
            wg.strb  = bus.wstrb;
            wg.size  = bus.awsize;
            wg.burst = bus.awburst;
            wg.data  = bus.wdata;
            wg.id    = bus.awid;
            log_q.push_back(int'(wg.id));
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL wr_issue unexpected start id=%0d", wg.id);
            end else begin
                we = wr_q.pop_front();
                if (wg !== we) begin
                    bad++;
                    $display("FAIL wr_issue got=%h exp=%h", wg, we);
                end
            end
        end
        if (resetn === 1'b0 && bus.rd_start === 1'b1) begin
            rg.addr  = bus.araddr;
            rg.id    = bus.arid;
            rg.len   = bus.arlen;
            rg.size  = bus.arsize;
            rg.burst = bus.arburst;
            log_q.push_back(16 + int'(rg.id));
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_issue unexpected start id=%0d", rg.id);
            end else begin
                re = rd_q.pop_front();
                if (rg !== re) begin
                    bad++;
                    $display("FAIL rd_issue got=%h exp=%h", rg, re);
                end
            end
        end
    end

    task automatic push_wr(input wr_cmd_t c);
        bit ok;
        ok = 1'b0;
        bus.wr_req_valid = 1'b1;
        bus.wr_req_addr  = c.addr;
        bus.wr_req_len   = c.len;
        bus.wr_req_strb  = c.strb;
        bus.wr_req_size  = c.size;
        bus.wr_req_burst = c.burst;
        bus.wr_req_data  = c.data;
        bus.wr_req_id    = c.id;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = bus.wr_req_ready;
            @(posedge clk);
            if (ok) wr_q.push_back(c);
            @(negedge clk);
        end
        bus.wr_req_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push_wr timeout id=%0d", c.id);
        end
    endtask

    task automatic push_rd(input rd_cmd_t c);
        bit ok;
        ok = 1'b0;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = c.addr;
        bus.rd_req_id    = c.id;
        bus.rd_req_len   = c.len;
        bus.rd_req_size  = c.size;
        bus.rd_req_burst = c.burst;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = bus.rd_req_ready;
            @(posedge clk);
            if (ok) rd_q.push_back(c);
            @(negedge clk);
        end
        bus.rd_req_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push_rd timeout id=%0d", c.id);
        end
    endtask

    task automatic wait_start(output bit is_rd);
        bit found;
        found = 1'b0;
        is_rd = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.wr_start === 1'b1 || bus.rd_start === 1'b1) begin
                found = 1'b1;
                is_rd = (bus.rd_start === 1'b1);
            end else begin
                @(negedge clk);
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_start timeout got=none exp=start");
        end
    endtask

    task automatic serve(input int lat);
        bit r;
        wait_start(r);
        repeat (lat) @(negedge clk);
        if (r) bus.rd_done = 1'b1;
        else   bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.busy, bus.wr_start, bus.rd_start} !== 3'b000) begin
            bad++;
            $display("FAIL rst_ctrl got=%b exp=000",
                     {bus.busy, bus.wr_start, bus.rd_start});
        end
        total++;
        if ({bus.wr_level, bus.rd_level} !== 6'd0) begin
            bad++;
            $display("FAIL rst_level got=%0d/%0d exp=0/0",
                     bus.wr_level, bus.rd_level);
        end
        total++;
        if ({bus.wr_req_ready, bus.rd_req_ready} !== 2'b11) begin
            bad++;
            $display("FAIL rst_ready got=%b exp=11",
                     {bus.wr_req_ready, bus.rd_req_ready});
        end
        total++;
        if (all_cmd() !== '0) begin
            bad++;
            $display("FAIL rst_cmd got=%h exp=0", all_cmd());
        end
        resetn = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.wr_start, bus.rd_start, bus.busy} !== 3'b000) begin
            bad++;
            $display("FAIL rst_release got=%b exp=000",
                     {bus.wr_start, bus.rd_start, bus.busy});
        end
    endtask

    task automatic test_single();
        wr_cmd_t c;
        c.addr  = 32'h100;
        c.len   = 4'd3;
        c.strb  = 4'hF;
        c.size  = 3'd2;
        c.burst = BURST_INCR;
        c.data  = 32'hDEADBEEF;
        c.id    = 4'd5;
        push_wr(c);
        total++;
        if (bus.wr_level !== 3'd1 || bus.wr_start !== 1'b0) begin
            bad++;
            $display("FAIL single_c1 got=lvl%0d/st%b exp=lvl1/st0",
                     bus.wr_level, bus.wr_start);
        end
        @(negedge clk);
        total++;
        if (bus.wr_start !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_start got=%b%b exp=11",
                     bus.wr_start, bus.busy);
        end
        total++;
        if (bus.awaddr !== 32'h100 || bus.awid !== 4'd5) begin
            bad++;
            $display("FAIL single_cmd got=%h/%0d exp=100/5",
                     bus.awaddr, bus.awid);
        end
        total++;
        if (bus.wr_level !== 3'd0) begin
            bad++;
            $display("FAIL single_pop got=%0d exp=0", bus.wr_level);
        end
        @(negedge clk);
        total++;
        if (bus.wr_start !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_wait got=%b%b exp=01",
                     bus.wr_start, bus.busy);
        end
        bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        push_wr(mk_wr(4'd6));
        total++;
        if (bus.wr_level !== 3'd1) begin
            bad++;
            $display("FAIL b2b_first got=%0d exp=1", bus.wr_level);
        end
        push_wr(mk_wr(4'd7));
        total++;
        if (bus.wr_level !== 3'd1) begin
            bad++;
            $display("FAIL b2b_pushpop got=%0d exp=1", bus.wr_level);
        end
        serve(2);
        serve(2);
        total++;
        if (bus.wr_level !== 3'd0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end got=%0d/%b exp=0/0",
                     bus.wr_level, bus.busy);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) push_wr(mk_wr(4'(i)));
        total++;
        if (bus.wr_level !== 3'd4) begin
            bad++;
            $display("FAIL fill_level got=%0d exp=4", bus.wr_level);
        end
        total++;
        if (bus.wr_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_ready got=%b exp=0", bus.wr_req_ready);
        end
        fork
            push_wr(mk_wr(4'd8));
            begin
                repeat (3) @(negedge clk);
                total++;
                if (bus.wr_level !== 3'd4 || bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL fill_hold got=%0d/%b exp=4/1",
                             bus.wr_level, bus.busy);
                end
                bus.wr_done = 1'b1;
                @(negedge clk);
                bus.wr_done = 1'b0;
            end
        join
        total++;
        if (bus.wr_level !== 3'd4 || bus.wr_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_refill got=%0d/%b exp=4/0",
                     bus.wr_level, bus.wr_req_ready);
        end
        bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        repeat (4) serve(1);
        total++;
        if (bus.wr_level !== 3'd0 || wr_q.size() != 0) begin
            bad++;
            $display("FAIL fill_drain got=%0d/%0d exp=0/0",
                     bus.wr_level, wr_q.size());
        end
    endtask

    task automatic test_round_robin();
        int exp_order [4];
        exp_order = '{1, 19, 2, 20};
        log_q.delete();
        fork
            begin
                push_wr(mk_wr(4'd1));
                push_wr(mk_wr(4'd2));
                push_rd(mk_rd(4'd3));
                push_rd(mk_rd(4'd4));
            end
            repeat (4) serve(3);
        join
        total++;
        if (log_q.size() != 4) begin
            bad++;
            $display("FAIL rr_count got=%0d exp=4", log_q.size());
        end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            total++;
            if (log_q[i] != exp_order[i]) begin
                bad++;
                $display("FAIL rr_order[%0d] got=%0d exp=%0d",
                         i, log_q[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_stray_done();
        bit r;
        push_wr(mk_wr(4'd9));
        wait_start(r);
        total++;
        if (r !== 1'b0) begin
            bad++;
            $display("FAIL stray_kind got=rd exp=wr");
        end
        bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1 || bus.wr_start !== 1'b0) begin
            bad++;
            $display("FAIL stray_wait got=%b%b exp=10",
                     bus.busy, bus.wr_start);
        end
        bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL stray_exit got=%b exp=0", bus.busy);
        end
        bus.wr_done = 1'b1;
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.busy, bus.wr_start, bus.rd_start} !== 3'b000) begin
                bad++;
                $display("FAIL stray_idle[%0d] got=%b exp=000", i,
                         {bus.busy, bus.wr_start, bus.rd_start});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit r;
        push_rd(mk_rd(4'd10));
        wait_start(r);
        total++;
        if (r !== 1'b1) begin
            bad++;
            $display("FAIL rmid_kind got=wr exp=rd");
        end
        push_wr(mk_wr(4'd11));
        push_wr(mk_wr(4'd12));
        total++;
        if (bus.wr_level !== 3'd2 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre got=%0d/%b exp=2/1",
                     bus.wr_level, bus.busy);
        end
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || {bus.wr_level, bus.rd_level} !== 6'd0) begin
            bad++;
            $display("FAIL rmid_state got=%b/%0d/%0d exp=0/0/0",
                     bus.busy, bus.wr_level, bus.rd_level);
        end
        total++;
        if (all_cmd() !== '0 || {bus.wr_start, bus.rd_start} !== 2'b00) begin
            bad++;
            $display("FAIL rmid_out got=%h exp=0", all_cmd());
        end
        resetn = 1'b0;
        wr_q.delete();
        rd_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if ({bus.wr_start, bus.rd_start, bus.busy} !== 3'b000) begin
                bad++;
                $display("FAIL rmid_after[%0d] got=%b exp=000", i,
                         {bus.wr_start, bus.rd_start, bus.busy});
            end
        end
    endtask

    initial begin
        resetn           = 1'b1;
        bus.wr_req_valid = 1'b0;
        bus.wr_req_addr  = '0;
        bus.wr_req_len   = '0;
        bus.wr_req_strb  = '0;
        bus.wr_req_size  = '0;
        bus.wr_req_burst = '0;
        bus.wr_req_data  = '0;
        bus.wr_req_id    = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_addr  = '0;
        bus.rd_req_id    = '0;
        bus.rd_req_len   = '0;
        bus.rd_req_size  = '0;
        bus.rd_req_burst = '0;
        bus.wr_done      = 1'b0;
        bus.rd_done      = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_round_robin();
        test_stray_done();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
